// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with input conditioning,
// 11-bit frame decoding (odd parity, stop bit, inter-edge timeout) and a
// byte FIFO presented on a valid/ready stream.
//
// Stream handshake: a byte transfers in every cycle where valid_o && ready_i
// are both high at the rising clock edge; data_o is stable while valid_o is
// high and no transfer occurs, and valid_o never drops without a transfer
// (except on reset).
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          ps2_clk_async_i,
  input  logic                          ps2_data_async_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic [1:0]                    state_o
);

  typedef logic [7:0] byte_t;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  // Input conditioning
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [1:0]             sync_w;   // [0] clock, [1] data
  logic [1:0]             filt_q;
  logic [FCW-1:0]         fcnt_q [2];
  logic                   filt_clk_prev_q;
  logic                   fall_w;
  logic                   din_w;

  // Frame decoder
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  byte_t       shift_q;
  logic        par_q;
  logic [TCW-1:0] tmo_q;
  logic        timeout_w;
  logic        push_req;
  logic        par_evt;
  logic        frm_evt;

  // FIFO
  byte_t       mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic        pop_w;
  logic        do_push;
  logic        ovf_evt;

  // Shift the raw lines through the synchroniser chains; idle lines are high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_async_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_async_i};
    end
  end

  assign sync_w = {data_sync_q[SYNC_STAGES-1], clk_sync_q[SYNC_STAGES-1]};

  // Same filter on both lines keeps clock/data alignment intact.
  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    // Accept a new level only after FILTER_LEN consecutive mismatching cycles.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        filt_q[gi] <= 1'b1;
        fcnt_q[gi] <= '0;
      end else if (sync_w[gi] != filt_q[gi]) begin
        if (fcnt_q[gi] == FCW'(FILTER_LEN - 1)) begin
          filt_q[gi] <= sync_w[gi];
          fcnt_q[gi] <= '0;
        end else begin
          fcnt_q[gi] <= fcnt_q[gi] + 1'b1;
        end
      end else begin
        fcnt_q[gi] <= '0;
      end
    end
  end

  // Remember the previous filtered clock for falling-edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) filt_clk_prev_q <= 1'b1;
    else         filt_clk_prev_q <= filt_q[0];
  end

  assign fall_w = filt_clk_prev_q & ~filt_q[0];
  assign din_w  = filt_q[1];

  // Frame FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign timeout_w = (state_q != S_IDLE) && !fall_w &&
                     (tmo_q == TCW'(TIMEOUT_CYCLES - 1));

  // Next-state and frame events; a timeout wins over everything else.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    par_evt  = 1'b0;
    frm_evt  = 1'b0;
    if (timeout_w) begin
      state_d = S_IDLE;
      frm_evt = 1'b1;
    end else if (fall_w) begin
      case (state_q)
        S_IDLE:   if (!din_w) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: begin
          if (par_q ^ din_w) begin
            state_d = S_STOP;
          end else begin
            state_d = S_IDLE;
            par_evt = 1'b1;
          end
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (din_w) push_req = 1'b1;
          else       frm_evt  = 1'b1;
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Shift register, bit counter, parity accumulator and inter-edge timer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      if (state_q == S_IDLE || fall_w) tmo_q <= '0;
      else                             tmo_q <= tmo_q + 1'b1;
      if (fall_w && !timeout_w) begin
        if (state_q == S_IDLE && !din_w) begin
          bit_cnt_q <= '0;
          par_q     <= 1'b0;
        end else if (state_q == S_DATA) begin
          shift_q   <= {din_w, shift_q[7:1]};
          par_q     <= par_q ^ din_w;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end

  assign count_o = wr_q - rd_q;
  assign valid_o = (count_o != '0);
  assign pop_w   = valid_o & ready_i;
  assign do_push = push_req && ((count_o != PW'(FIFO_DEPTH)) || pop_w);
  assign ovf_evt = push_req && !do_push;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign state_o = state_q;

  // FIFO storage and pointers; on a full push+pop the write reuses the freed slot.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= shift_q;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_w) rd_q <= rd_q + 1'b1;
    end
  end

  // Register error events into single-cycle pulses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      parity_err_o <= par_evt;
      frame_err_o  <= frm_evt;
      overflow_o   <= ovf_evt;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: bench for ps2_rx_fifo with FILTER_LEN=8, TIMEOUT_CYCLES=1000,
// FIFO_DEPTH=4. PS/2 frames are bit-banged on the raw pins; received bytes are
// checked against an expected queue as the consumer accepts them.
module tb_ps2_rx_fifo;

  localparam int HALF  = 30;
  localparam int DEPTH = 4;
  localparam int TMO   = 1000;
  localparam int LAT   = 10;   // SYNC_STAGES + FILTER_LEN

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] count_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic [1:0] state_o;

  ps2_rx_fifo #(
    .SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ps2_clk_async_i(ps2_clk), .ps2_data_async_i(ps2_data),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
    .overflow_o(overflow_o), .state_o(state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int par_cnt = 0, frm_cnt = 0, ovf_cnt = 0, wide_cnt = 0;
  logic par_prev = 1'b0, frm_prev = 1'b0, ovf_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Scoreboard and pulse monitor, sampled on the falling clock edge.
  always @(negedge clk_i) begin
    if (!reset_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got byte 0x%0h, expected no byte", data_o);
      end else begin
        check("pop_data", int'(data_o), int'(exp_q.pop_front()));
      end
    end
    if (parity_err_o) par_cnt++;
    if (frame_err_o)  frm_cnt++;
    if (overflow_o)   ovf_cnt++;
    if ((parity_err_o && par_prev) || (frame_err_o && frm_prev) || (overflow_o && ovf_prev))
      wide_cnt++;
    par_prev = parity_err_o;
    frm_prev = frame_err_o;
    ovf_prev = overflow_o;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    @(negedge clk_i); ps2_data = b;
    repeat (HALF) @(negedge clk_i); ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk_i); ps2_clk = 1'b1;
  endtask

  // Full frame; rdy_on_stop pulses ready_i in the cycle the stop edge is seen.
  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_bit,
                            input bit rdy_on_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_ok ? ~^d : ^d);
    if (rdy_on_stop) begin
      @(negedge clk_i); ps2_data = stop_bit;
      repeat (HALF) @(negedge clk_i); ps2_clk = 1'b0;
      repeat (LAT) @(posedge clk_i);
      #1 ready_i = 1'b1;
      @(posedge clk_i);
      #1 ready_i = 1'b0;
      repeat (HALF) @(negedge clk_i); ps2_clk = 1'b1;
    end else begin
      send_bit(stop_bit);
    end
    @(negedge clk_i); ps2_data = 1'b1;
    repeat (HALF) @(negedge clk_i);
  endtask

  task automatic drain();
    @(posedge clk_i); #1 ready_i = 1'b1;
    repeat (DEPTH + 4) @(posedge clk_i);
    #1 ready_i = 1'b0;
    check("drain_count", int'(count_o), 0);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         par_ok;
    bit         stop_bit;
    int         exp_par;
    int         exp_frm;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[6];
  int p0, f0, o0, k;
  bit found;

  initial begin
    vecs[0] = '{8'h1C, 1'b1, 1'b1, 0, 0, 1};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1, 0, 0};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 0, 0, 1};
    vecs[3] = '{8'h33, 1'b1, 1'b0, 0, 1, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 0, 0, 1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 0, 0, 1};

    // Reset
    reset_i = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", int'(valid_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_state", int'(state_o), 0);
    check("rst_errs", int'({parity_err_o, frame_err_o, overflow_o}), 0);
    reset_i = 1'b0;
    repeat (20) @(negedge clk_i);

    // Table of single frames: good, parity error, stop error
    for (int i = 0; i < 6; i++) begin
      p0 = par_cnt; f0 = frm_cnt;
      if (vecs[i].exp_cnt != 0) exp_q.push_back(vecs[i].d);
      send_frame(vecs[i].d, vecs[i].par_ok, vecs[i].stop_bit, 1'b0);
      check($sformatf("vec%0d_par_err", i), par_cnt - p0, vecs[i].exp_par);
      check($sformatf("vec%0d_frm_err", i), frm_cnt - f0, vecs[i].exp_frm);
      check($sformatf("vec%0d_count", i), int'(count_o), vecs[i].exp_cnt);
      check($sformatf("vec%0d_valid", i), int'(valid_o), vecs[i].exp_cnt);
      if (vecs[i].exp_cnt != 0) check($sformatf("vec%0d_data", i), int'(data_o), int'(vecs[i].d));
      @(posedge clk_i); #1 ready_i = 1'b1;
      @(posedge clk_i); #1 ready_i = 1'b0;
      check($sformatf("vec%0d_valid_after_pop", i), int'(valid_o), 0);
      check($sformatf("vec%0d_count_after_pop", i), int'(count_o), 0);
    end

    // Glitch rejection on the PS/2 clock with data low in IDLE
    @(negedge clk_i); ps2_data = 1'b0;
    repeat (20) @(negedge clk_i); ps2_clk = 1'b0;
    repeat (5) @(negedge clk_i); ps2_clk = 1'b1;
    repeat (30) @(negedge clk_i);
    check("glitch5_state_idle", int'(state_o), 0);
    ps2_clk = 1'b0;
    repeat (12) @(negedge clk_i); ps2_clk = 1'b1;
    repeat (30) @(negedge clk_i);
    check("glitch12_state_data", int'(state_o), 1);
    ps2_data = 1'b1;
    f0 = frm_cnt;
    k = 0;
    while (k < TMO + 100 && frm_cnt == f0) begin @(negedge clk_i); k++; end
    check("glitch12_timeout_err", frm_cnt - f0, 1);
    check("glitch12_back_idle", int'(state_o), 0);
    repeat (20) @(negedge clk_i);

    // Timeout after four data bits, measured from the last raw falling edge
    f0 = frm_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk_i); ps2_data = 1'b0;
    repeat (HALF) @(negedge clk_i); ps2_clk = 1'b0;
    k = 0; found = 1'b0;
    while (k < TMO + 200 && !found) begin
      @(posedge clk_i); k++;
      #1;
      if (frame_err_o) found = 1'b1;
      if (k == HALF) ps2_clk = 1'b1;
    end
    check("timeout_seen", int'(found), 1);
    check("timeout_cycle", k, LAT + TMO + 1);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (20) @(negedge clk_i);
    check("timeout_err_count", frm_cnt - f0, 1);
    check("timeout_state_idle", int'(state_o), 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check("after_timeout_count", int'(count_o), 1);
    drain();

    // Overflow with ready low
    o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    end
    check("ovf_count_full", int'(count_o), DEPTH);
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("ovf_head", int'(data_o), 1);
    drain();

    // Full FIFO with a pop in the stop-edge cycle
    o0 = ovf_cnt;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    end
    exp_q.push_back(8'h05);
    send_frame(8'h05, 1'b1, 1'b1, 1'b1);
    check("pushpop_no_ovf", ovf_cnt - o0, 0);
    check("pushpop_count", int'(count_o), DEPTH);
    check("pushpop_head", int'(data_o), 2);
    drain();

    // Asynchronous reset mid-frame with two bytes queued
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h22); send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    check("prereset_count", int'(count_o), 2);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(posedge clk_i);
    #3 reset_i = 1'b1;
    #1;
    check("midreset_valid", int'(valid_o), 0);
    check("midreset_count", int'(count_o), 0);
    check("midreset_state", int'(state_o), 0);
    exp_q.delete();
    #2 reset_i = 1'b0;
    ps2_data = 1'b1;
    repeat (20) @(negedge clk_i);
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
    check("postreset_count", int'(count_o), 1);
    check("postreset_data", int'(data_o), 8'hAA);
    drain();

    check("pulse_widths_single", wide_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
